// File: rtl/fake_n64_controller_tx.sv
// ---------------------------------------------------------------------------
// fake_n64_controller_tx
//
// Reply transmitter for the fake N64 controller. Every toggle of tx_handoff
// (from the command receiver, asynchronous to clk) starts one reply. The
// reply is chosen by the command byte sampled at that moment and is sent
// MSB first on the one-wire line using N64 pulse-width bit encoding.
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   tx_handoff     toggle request from the receiver (either edge)
//   cmd, crc       command byte and data CRC, sampled on handoff detection
//   buttons        button/stick word, [31:24] sent first
//   pak_status     third byte of the INFO reply
//   rd_addr        byte index into the 32-byte read buffer
//   rd_data        read buffer data, valid one clk after rd_addr changes
//   data_tx        line drive: 0 = pull low, 1 = release
//   cur_operation  high from turnaround through the end of the stop bit
//   tx_done        one-cycle pulse when the line is released after stop
// ---------------------------------------------------------------------------
module fake_n64_controller_tx #(
    parameter int CLKS_PER_US   = 4,
    parameter int TURNAROUND_US = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_handoff,
    input  logic [7:0]  cmd,
    input  logic [7:0]  crc,
    input  logic [31:0] buttons,
    input  logic [7:0]  pak_status,
    output logic [4:0]  rd_addr,
    input  logic [7:0]  rd_data,
    output logic        data_tx,
    output logic        cur_operation,
    output logic        tx_done
);

    localparam int T      = CLKS_PER_US;
    localparam int TA_CYC = TURNAROUND_US * T;
    // One phase counter serves both the turnaround gap and the bit halves.
    localparam int PH_MAX = (TA_CYC > 3 * T) ? TA_CYC : 3 * T;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0] PH_1T = PH_W'(T - 1);
    localparam logic [PH_W-1:0] PH_2T = PH_W'(2 * T - 1);
    localparam logic [PH_W-1:0] PH_3T = PH_W'(3 * T - 1);
    localparam logic [PH_W-1:0] PH_TA = PH_W'(TA_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        TURNAROUND,
        BIT_LOW,
        BIT_HIGH,
        STOP_LOW,
        DONE
    } state_t;

    state_t          state;
    logic [PH_W-1:0] phase;
    logic [2:0]      bit_idx;
    logic [5:0]      byte_idx;
    logic [5:0]      byte_total;
    logic [7:0]      shreg;

    logic [7:0]      cmd_q;
    logic [7:0]      crc_q;
    logic [31:0]     buttons_q;
    logic [7:0]      pak_q;
    logic [7:0]      rd_buf;
    logic [1:0]      cap_pipe;

    logic            sync1, sync2, sync_prev;
    logic            handoff_edge;

    // -----------------------------------------------------------------------
    // Handoff synchroniser and edge detect. The edge register runs in every
    // state, so an edge that arrives while busy is consumed and lost.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= tx_handoff;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign handoff_edge = sync2 ^ sync_prev;

    function automatic logic [5:0] reply_len(input logic [7:0] c);
        case (c)
            8'h00, 8'hFF: reply_len = 6'd3;
            8'h01:        reply_len = 6'd4;
            8'h02:        reply_len = 6'd33;
            8'h03:        reply_len = 6'd1;
            default:      reply_len = 6'd0;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Next byte to load into the shifter. At the end of turnaround it is
    // byte 0, otherwise the byte after the one currently shifting.
    // -----------------------------------------------------------------------
    logic [5:0] fetch_idx;
    logic [7:0] fetch_byte;
    logic [5:0] next_addr_w;
    logic [4:0] next_addr;
    logic       is_read;

    assign fetch_idx   = (state == TURNAROUND) ? 6'd0 : byte_idx + 6'd1;
    assign is_read     = (cmd_q == 8'h02);
    // The read pointer runs one byte ahead of the shifter; it pins at 31
    // because the last READ byte is the CRC, not buffer data.
    assign next_addr_w = fetch_idx + 6'd1;
    assign next_addr   = (next_addr_w > 6'd31) ? 5'd31 : next_addr_w[4:0];

    always_comb begin
        fetch_byte = 8'h00;
        case (cmd_q)
            8'h00, 8'hFF: begin
                case (fetch_idx[1:0])
                    2'd0:    fetch_byte = 8'h05;
                    2'd1:    fetch_byte = 8'h00;
                    default: fetch_byte = pak_q;
                endcase
            end
            8'h01: begin
                case (fetch_idx[1:0])
                    2'd0:    fetch_byte = buttons_q[31:24];
                    2'd1:    fetch_byte = buttons_q[23:16];
                    2'd2:    fetch_byte = buttons_q[15:8];
                    default: fetch_byte = buttons_q[7:0];
                endcase
            end
            8'h02:   fetch_byte = (fetch_idx == 6'd32) ? crc_q : rd_buf;
            8'h03:   fetch_byte = crc_q;
            default: fetch_byte = 8'h00;
        endcase
    end

    // Pulse widths of the bit currently at the head of the shifter.
    logic [PH_W-1:0] low_end, high_end;
    assign low_end  = shreg[7] ? PH_1T : PH_3T;
    assign high_end = shreg[7] ? PH_3T : PH_1T;

    // -----------------------------------------------------------------------
    // Reply FSM with registered line outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            phase         <= '0;
            bit_idx       <= '0;
            byte_idx      <= '0;
            byte_total    <= '0;
            shreg         <= '0;
            cmd_q         <= '0;
            crc_q         <= '0;
            buttons_q     <= '0;
            pak_q         <= '0;
            rd_buf        <= '0;
            cap_pipe      <= '0;
            rd_addr       <= '0;
            data_tx       <= 1'b1;
            cur_operation <= 1'b0;
            tx_done       <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            // rd_data is sampled on both of the two cycles after an address
            // change; the later sample is the one that survives, which
            // covers a buffer with a registered read port.
            cap_pipe <= {cap_pipe[0], 1'b0};
            if (|cap_pipe)
                rd_buf <= rd_data;

            case (state)
                IDLE: begin
                    if (handoff_edge) begin
                        cmd_q         <= cmd;
                        crc_q         <= crc;
                        buttons_q     <= buttons;
                        pak_q         <= pak_status;
                        byte_total    <= reply_len(cmd);
                        cur_operation <= 1'b1;
                        phase         <= '0;
                        rd_addr       <= 5'd0;
                        cap_pipe      <= 2'b01;
                        state         <= TURNAROUND;
                    end
                end

                TURNAROUND: begin
                    if (byte_total == 6'd0) begin
                        // Unknown command: drop back without touching the line.
                        cur_operation <= 1'b0;
                        state         <= IDLE;
                    end else if (phase == PH_TA) begin
                        shreg    <= fetch_byte;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        phase    <= '0;
                        data_tx  <= 1'b0;
                        state    <= BIT_LOW;
                        if (is_read) begin
                            rd_addr  <= next_addr;
                            cap_pipe <= 2'b01;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                BIT_LOW: begin
                    if (phase == low_end) begin
                        phase   <= '0;
                        data_tx <= 1'b1;
                        state   <= BIT_HIGH;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                BIT_HIGH: begin
                    if (phase == high_end) begin
                        phase   <= '0;
                        data_tx <= 1'b0;
                        if (bit_idx == 3'd7) begin
                            if (byte_idx == byte_total - 6'd1) begin
                                state <= STOP_LOW;
                            end else begin
                                shreg    <= fetch_byte;
                                byte_idx <= byte_idx + 6'd1;
                                bit_idx  <= '0;
                                state    <= BIT_LOW;
                                if (is_read) begin
                                    rd_addr  <= next_addr;
                                    cap_pipe <= 2'b01;
                                end
                            end
                        end else begin
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_idx <= bit_idx + 3'd1;
                            state   <= BIT_LOW;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                STOP_LOW: begin
                    if (phase == PH_2T) begin
                        phase         <= '0;
                        data_tx       <= 1'b1;
                        cur_operation <= 1'b0;
                        tx_done       <= 1'b1;
                        rd_addr       <= 5'd0;
                        state         <= DONE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    data_tx       <= 1'b1;
                    cur_operation <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
